// File: rtl/load_extract_unit_pkg.sv
// Shared load-path definitions: load op encodings, FSM states, byte-lane indices
// and the alignment legality check used when a load request is accepted.
package load_extract_unit_pkg;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_HU = 3'b010;
    localparam logic [2:0] LD_B  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;

    // Byte-lane indices; the store-side byte-enable logic uses the same numbering.
    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Illegal op, unaligned word, or odd halfword address raises AdEL.
    function automatic logic load_addr_error(input logic [2:0] op, input logic [1:0] b);
        logic err;
        case (op)
            LD_W:         err = (b != LANE0);
            LD_H, LD_HU:  err = b[0];
            LD_B, LD_BU:  err = 1'b0;
            default:      err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_extract_unit_load_ext.sv
// Combinational load extraction: selects the addressed byte/halfword of the bus
// word and zero- or sign-extends it to 32 bits.
module load_ext
    import load_extract_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  b,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (b)
            LANE0:   byte_sel = word[7:0];
            LANE1:   byte_sel = word[15:8];
            LANE2:   byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = b[1] ? word[31:16] : word[15:0];

        // Size casts of the signed selects sign-extend; the unsigned forms zero-fill.
        result = '0;
        case (op)
            LD_W:    result = word;
            LD_H:    result = 32'(half_sel);
            LD_HU:   result = {16'h0000, half_sel};
            LD_B:    result = 32'(byte_sel);
            LD_BU:   result = {24'h000000, byte_sel};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_extract_unit.sv
// Load unit: accepts one request, issues a word-aligned bus read, waits with a
// timeout, then returns the extended byte/halfword/word with a one-cycle valid.
module load_extract_unit
    import load_extract_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_op,
    output logic        bus_rd_en,
    output logic [31:0] bus_addr,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        adel,
    output logic        bus_err,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_p0;
    logic [1:0]       b_p0;
    logic             req_err;
    logic             accept;
    logic             timeout_hit;
    logic [31:0]      ext_data;

    assign req_err = load_addr_error(req_op, req_addr[1:0]);

    load_ext u_load_ext (
        .op     (op_p0),
        .b      (b_p0),
        .word   (bus_rdata),
        .result (ext_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = req_err ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                // Response on the timeout cycle still wins over the timeout.
                if (bus_rvalid) begin
                    state_nxt = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs and request capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            bus_rd_en <= 1'b0;
            bus_addr  <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            adel      <= 1'b0;
            bus_err   <= 1'b0;
            cnt       <= '0;
            op_p0     <= '0;
            b_p0      <= '0;
        end else begin
            req_ready <= (state_nxt == ST_IDLE);
            busy      <= (state_nxt != ST_IDLE);
            bus_rd_en <= accept && !req_err;
            rd_valid  <= (state_nxt == ST_DONE);

            if (accept) begin
                op_p0    <= req_op;
                b_p0     <= req_addr[1:0];
                bus_addr <= {req_addr[31:2], 2'b00};
                if (req_err) begin
                    adel    <= 1'b1;
                    bus_err <= 1'b0;
                    rd_data <= '0;
                end
            end

            if (state == ST_ISSUE) begin
                cnt <= '0;
            end

            if (state == ST_WAIT) begin
                if (bus_rvalid) begin
                    rd_data <= ext_data;
                    adel    <= 1'b0;
                    bus_err <= 1'b0;
                end else if (timeout_hit) begin
                    rd_data <= '0;
                    adel    <= 1'b0;
                    bus_err <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_load_extract_unit.sv
// Directed bench for load_extract_unit: table of load vectors plus hand-written
// reset-abort and back-to-back sequences.
module tb_load_extract_unit;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_op;
    logic        bus_rd_en;
    logic [31:0] bus_addr;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        adel;
    logic        bus_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_extract_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_op     (req_op),
        .bus_rd_en  (bus_rd_en),
        .bus_addr   (bus_addr),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .adel       (adel),
        .bus_err    (bus_err),
        .busy       (busy)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] word;
        int          rv_at;     // WAIT cycle (1-based) carrying bus_rvalid; -1 = never
        logic [31:0] exp_data;
        logic        exp_adel;
        logic        exp_berr;
        int          exp_lat;   // clock edges from the accept edge (inclusive) to rd_valid
        logic        stray;     // drive a stray response after rd_valid
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_req(input string nm, input vec_t v);
        int          n;
        int          rden;
        logic        seen;
        logic [31:0] exp_baddr;
        exp_baddr = {v.addr[31:2], 2'b00};
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n    = 1;
        rden = 0;
        seen = 1'b0;
        while (!seen && n <= 40) begin
            @(negedge clk);
            if (bus_rd_en) begin
                rden++;
                chk({nm, " bus_addr"}, bus_addr, exp_baddr);
            end
            if (rd_valid) begin
                seen = 1'b1;
                chk({nm, " latency"}, 32'(n), 32'(v.exp_lat));
                chk({nm, " rd_data"}, rd_data, v.exp_data);
                chk({nm, " adel"}, 32'(adel), 32'(v.exp_adel));
                chk({nm, " bus_err"}, 32'(bus_err), 32'(v.exp_berr));
            end else begin
                bus_rvalid = (v.rv_at > 0) && (n == v.rv_at + 1);
                bus_rdata  = bus_rvalid ? v.word : 32'h0;
                @(posedge clk);
                n++;
            end
        end
        bus_rvalid = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s rd_valid: got none within 40 cycles expected pulse", nm);
        end else begin
            chk({nm, " rd_en count"}, 32'(rden), v.exp_adel ? 32'd0 : 32'd1);
            if (v.stray) begin
                bus_rvalid = 1'b1;
                bus_rdata  = 32'hDEADBEEF;
            end
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk({nm, " rd_valid after"}, 32'(rd_valid), 32'd0);
                chk({nm, " rd_data held"}, rd_data, v.exp_data);
                chk({nm, " req_ready after"}, 32'(req_ready), 32'd1);
                chk({nm, " busy after"}, 32'(busy), 32'd0);
            end
            bus_rvalid = 1'b0;
        end
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, " bus_rd_en"}, 32'(bus_rd_en), 32'd0);
        chk({nm, " bus_addr"}, bus_addr, 32'h0);
        chk({nm, " rd_valid"}, 32'(rd_valid), 32'd0);
        chk({nm, " rd_data"}, rd_data, 32'h0);
        chk({nm, " adel"}, 32'(adel), 32'd0);
        chk({nm, " bus_err"}, 32'(bus_err), 32'd0);
        chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
        chk({nm, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] exp_busy;
        logic [8:0] exp_rv;
        logic [8:0] exp_rden;

        //          op      addr          word          rv  exp_data      adel  berr  lat stray
        vecs[0]  = '{OP_LB,  32'h0000_1003, 32'h80FF1234,  2, 32'hFFFFFF80, 1'b0, 1'b0,  4, 1'b0};
        vecs[1]  = '{OP_LBU, 32'h0000_1003, 32'h80FF1234,  2, 32'h00000080, 1'b0, 1'b0,  4, 1'b0};
        vecs[2]  = '{OP_LHU, 32'h0000_1002, 32'h80FF1234,  2, 32'h000080FF, 1'b0, 1'b0,  4, 1'b0};
        vecs[3]  = '{OP_LH,  32'h0000_1002, 32'h80FF1234,  2, 32'hFFFF80FF, 1'b0, 1'b0,  4, 1'b0};
        vecs[4]  = '{OP_LW,  32'h0000_1000, 32'h80FF1234,  2, 32'h80FF1234, 1'b0, 1'b0,  4, 1'b0};
        vecs[5]  = '{OP_LB,  32'h0000_1000, 32'h80FF1234,  1, 32'h00000034, 1'b0, 1'b0,  3, 1'b1};
        vecs[6]  = '{OP_LB,  32'h0000_1002, 32'h80FF1234,  1, 32'hFFFFFFFF, 1'b0, 1'b0,  3, 1'b0};
        vecs[7]  = '{OP_LH,  32'h0000_1000, 32'h12348001,  3, 32'hFFFF8001, 1'b0, 1'b0,  5, 1'b0};
        vecs[8]  = '{OP_LW,  32'h0000_1001, 32'h80FF1234,  1, 32'h00000000, 1'b1, 1'b0,  1, 1'b0};
        vecs[9]  = '{OP_LBU, 32'h0000_1001, 32'h80FF1234,  1, 32'h00000012, 1'b0, 1'b0,  3, 1'b0};
        vecs[10] = '{OP_LH,  32'h0000_1003, 32'h80FF1234,  1, 32'h00000000, 1'b1, 1'b0,  1, 1'b0};
        vecs[11] = '{3'b111, 32'h0000_1000, 32'h80FF1234,  1, 32'h00000000, 1'b1, 1'b0,  1, 1'b0};
        vecs[12] = '{OP_LHU, 32'h0000_1001, 32'h80FF1234,  1, 32'h00000000, 1'b1, 1'b0,  1, 1'b0};
        vecs[13] = '{OP_LW,  32'h0000_2004, 32'hCAFEF00D,  1, 32'hCAFEF00D, 1'b0, 1'b0,  3, 1'b0};
        vecs[14] = '{OP_LW,  32'h0000_2000, 32'h80FF1234, -1, 32'h00000000, 1'b0, 1'b1, 18, 1'b1};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_op     = '0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        #12;
        chk_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset during WAIT aborts, and a response arriving afterwards is dropped.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_LW;
        req_addr  = 32'h0000_3000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_state("mid reset");
        @(negedge clk);
        reset      = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            chk("post reset rd_valid", 32'(rd_valid), 32'd0);
            chk("post reset rd_data", rd_data, 32'h0);
            chk("post reset req_ready", 32'(req_ready), 32'd1);
        end
        run_req("after reset lbu",
                '{OP_LBU, 32'h0000_3002, 32'hAABBCCDD, 1, 32'h000000BB, 1'b0, 1'b0, 3, 1'b0});

        // Back-to-back: second request held valid, taken at the first IDLE edge.
        exp_busy = 9'b001110111;
        exp_rv   = 9'b001000100;
        exp_rden = 9'b000010001;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_LW;
        req_addr  = 32'h0000_4000;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) begin
                req_op   = OP_LH;
                req_addr = 32'h0000_4002;
            end
            if (k == 4) req_valid = 1'b0;
            chk($sformatf("b2b busy k%0d", k), 32'(busy), 32'(exp_busy[k]));
            chk($sformatf("b2b rd_valid k%0d", k), 32'(rd_valid), 32'(exp_rv[k]));
            chk($sformatf("b2b bus_rd_en k%0d", k), 32'(bus_rd_en), 32'(exp_rden[k]));
            if (k == 2) chk("b2b first rd_data", rd_data, 32'h11223344);
            if (k == 4) chk("b2b second bus_addr", bus_addr, 32'h0000_4000);
            if (k == 6) chk("b2b second rd_data", rd_data, 32'hFFFF8000);
            bus_rvalid = (k == 1) || (k == 5);
            bus_rdata  = (k == 1) ? 32'h11223344 : ((k == 5) ? 32'h80007FFF : 32'h0);
        end
        bus_rvalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_extract_unit.md
Name: load_extract_unit

Overview:
- Load-side counterpart of the store byte-lane/alignment logic in the data-memory path.
- Accepts one load request at a time from the M stage and issues a word-aligned read on the data bus.
- Waits a variable number of cycles for the bus response, then extracts and zero- or sign-extends the addressed byte or halfword and returns it with a one-cycle valid.
- Detects misaligned or illegal loads (AdEL) and bus timeouts; no bus access is made for rejected requests.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles before the request is abandoned; legal range 2..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  32  byte address.
- req_op  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101..111 are illegal.
- bus_rd_en  out  1  one-cycle read strobe.
- bus_addr  out  32  word address, {addr[31:2],2'b00}; held stable from ISSUE through WAIT.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read word.
- rd_valid  out  1  result valid; pulses for one cycle.
- rd_data  out  32  extended load result.
- adel  out  1  address/op error; qualified by rd_valid.
- bus_err  out  1  timeout error; qualified by rd_valid.
- busy  out  1  high when state is not IDLE (pipeline stall).

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- Reset:
  - State goes to IDLE.
  - bus_rd_en, bus_addr, rd_valid, rd_data, adel, bus_err and the counter all go to 0.
  - req_ready is 1 and busy is 0.
- IDLE:
  - Acceptance happens when req_valid is high at a rising edge.
  - Captured at acceptance: addr[1:0], op, and bus_addr.
  - Error condition: op is illegal, or (lw and addr[1:0]!=0), or (lh/lhu and addr[0]=1).
  - On error: go to DONE with adel=1 and rd_data=0; no bus_rd_en is issued.
  - Otherwise: go to ISSUE.
- ISSUE:
  - bus_rd_en=1 for exactly this cycle; then go to WAIT with counter=0.
  - bus_rvalid during ISSUE is ignored; the bus responds no earlier than the following cycle.
- WAIT:
  - On bus_rvalid: capture the extracted data and go to DONE.
  - Otherwise the counter increments. When counter==TIMEOUT-1 and bus_rvalid is still low: go to DONE with bus_err=1 and rd_data=0.
  - If bus_rvalid arrives on the same cycle as the timeout, the data wins and bus_err=0.
- DONE:
  - rd_valid=1 for one cycle, then go to IDLE.
  - adel, bus_err and rd_data hold until the next DONE; they are only meaningful while rd_valid is high.
- Extraction, with b = addr[1:0]:
  - lw: the whole word.
  - lb: sign-extend byte[b]. lbu: zero-extend byte[b].
  - lh: sign-extend halfword[b[1]]. lhu: zero-extend halfword[b[1]].
- Latency: accept edge → ISSUE → WAIT (≥1 cycle) → DONE. Minimum is 3 cycles from acceptance to rd_valid. An error is reported 1 cycle after acceptance.
- Back-to-back: a new request can be accepted in the cycle after DONE, because IDLE is entered at that edge.
- Stray responses: bus_rvalid in IDLE or DONE is ignored.
- A late response after a timeout must not corrupt rd_data.
- Reset asserted mid-operation immediately aborts to the IDLE reset state. A pending response is discarded and no rd_valid pulse is produced.

Decomposition:
- Shared package (e.g. mem_pkg):
  - Load op encodings (LD_W, LD_H, LD_HU, LD_B, LD_BU).
  - State encoding.
  - The lane-index constants shared with the store-side byte-enable logic.
- Natural sub-module: load_ext, purely combinational (op, b, word → 32-bit result), instantiated once at the WAIT capture point. The FSM and timeout counter stay in the top module.

Test Plan:
- lb, addr=0x1003, bus_rdata=0x80FF1234 at the 2nd WAIT cycle → rd_data=0xFFFFFF80, adel=0, bus_err=0, rd_valid 4 cycles after acceptance.
- lbu, addr=0x1003, same word → 0x00000080. lhu, addr=0x1002 → 0x000080FF. lh, addr=0x1002 → 0xFFFF80FF. lw, addr=0x1000 → 0x80FF1234. In all cases bus_addr=0x1000.
- lw, addr=0x1001; lh, addr=0x1003; op=3'b111 → each gives adel=1, rd_data=0, bus_rd_en never asserted, rd_valid exactly 1 cycle after acceptance.
- No bus_rvalid with TIMEOUT=16 → bus_err=1 after 16 WAIT cycles. A bus_rvalid on the following cycle is ignored and no second rd_valid pulse occurs.
- Reset asserted during WAIT, then bus_rvalid pulsed → all outputs 0, no rd_valid, req_ready=1. A subsequent lbu completes normally.
- Two back-to-back requests, each answered with 1-cycle latency → second accepted the cycle after the first rd_valid; both results correct; busy low only in the IDLE cycles.
